// File: rtl/accu_pkg.sv
// Shared definitions for the windowed accumulator: state encodings,
// result-width rule and window-length decode.
package accu_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;  // no window open
    localparam logic [0:0] ST_ACCUM = 1'b1;  // window open, samples being summed

    // Minimum result width that cannot overflow when summing win_max samples.
    function automatic int out_w_min(input int in_w, input int win_max);
        return in_w + $clog2(win_max);
    endfunction

    // A window length of zero selects the longest window.
    function automatic int unsigned decode_len(input int unsigned len, input int unsigned win_max);
        return (len == 0) ? win_max : len;
    endfunction

endpackage

// File: rtl/accu_lane.sv
// One channel of the window accumulator: sign-extending adder feeding an
// accumulator register with zero/enable controls.
module accu_lane
    import accu_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 38
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    zero_i,
    input  logic                    en_i,
    input  logic [IN_W-1:0]         din_i,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [OUT_W-1:0] acc_q, acc_d;

    assign sum_o = acc_q + OUT_W'(signed'(din_i));

    always_comb begin
        acc_d = acc_q;
        if (zero_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/accu_window.sv
// Multi-channel windowed accumulator with a held, handshaked result.
// Define ACCU_OVR_EN to add the sticky 'ovr' output flagging overwritten results.
module accu_window
    import accu_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CH      = 4,
    parameter int WIN_MAX = 64,
    parameter int OUT_W   = out_w_min(IN_W, WIN_MAX)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [$clog2(WIN_MAX+1)-1:0]  win_len,
    input  logic                          in_valid,
    input  logic [CH*IN_W-1:0]            din,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH*OUT_W-1:0]           dout,
    output logic [$clog2(WIN_MAX+1)-1:0]  win_cnt
`ifdef ACCU_OVR_EN
    ,
    output logic                          ovr
`endif
);

    localparam int CW = $clog2(WIN_MAX+1);

    if (OUT_W < out_w_min(IN_W, WIN_MAX)) begin : g_width_chk
        $error("accu_window: OUT_W too narrow for IN_W and WIN_MAX");
    end

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       len_eff;
    logic                done;
    logic                lane_zero;
    logic                out_valid_q, out_valid_d;
    logic [CH*OUT_W-1:0] dout_q, dout_d;
    logic [CH*OUT_W-1:0] sums;

    // The first sample of a window uses the live win_len; later ones the latched copy.
    assign len_eff   = (state_q == ST_IDLE) ? CW'(decode_len(32'(win_len), WIN_MAX)) : len_q;
    assign done      = in_valid && !clear && ((cnt_q + CW'(1)) == len_eff);
    assign lane_zero = clear || done;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        accu_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .zero_i (lane_zero),
            .en_i   (in_valid),
            .din_i  (din[g*IN_W +: IN_W]),
            .sum_o  (sums[g*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (in_valid) begin
            if (state_q == ST_IDLE) begin
                len_d = len_eff;
            end
            if (done) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                state_d = ST_ACCUM;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // A new completion always wins over an accept in the same cycle.
    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done) begin
            dout_d      = sums;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= CW'(WIN_MAX);
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign win_cnt   = cnt_q;

`ifdef ACCU_OVR_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (clear) begin
            ovr_d = 1'b0;
        end else if (done && out_valid_q && !out_ready) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_accu_window.sv
// Self-checking bench for accu_window: behavioural window model feeding a
// scoreboard queue of expected results, one task per scenario.
module tb_accu_window;

    localparam int IN_W    = 32;
    localparam int CH      = 4;
    localparam int WIN_MAX = 64;
    localparam int OUT_W   = IN_W + $clog2(WIN_MAX);
    localparam int CW      = $clog2(WIN_MAX+1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic [CW-1:0]        win_len = '0;
    logic                 in_valid = 1'b0;
    logic [CH*IN_W-1:0]   din = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [CH*OUT_W-1:0]  dout;
    logic [CW-1:0]        win_cnt;
`ifdef ACCU_OVR_EN
    logic                 ovr;
`endif

    int errors = 0;
    int checks = 0;

    logic [CH*OUT_W-1:0] exp_q[$];
    logic [CH*OUT_W-1:0] exp_v;
    longint              m_acc[CH];
    int                  m_cnt = 0;
    int                  m_len = WIN_MAX;
    longint              smp[CH];

    accu_window #(
        .IN_W    (IN_W),
        .CH      (CH),
        .WIN_MAX (WIN_MAX),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .win_len   (win_len),
        .in_valid  (in_valid),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .win_cnt   (win_cnt)
`ifdef ACCU_OVR_EN
        ,
        .ovr       (ovr)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int l = 0; l < CH; l++) m_acc[l] = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic set_all(input longint val);
        for (int l = 0; l < CH; l++) smp[l] = val;
    endtask

    // Drive one cycle; the model pushes an expected result when a window closes.
    task automatic step(input logic v, input logic clr, output bit done);
        done     = 1'b0;
        in_valid = v;
        clear    = clr;
        for (int l = 0; l < CH; l++) din[l*IN_W +: IN_W] = smp[l][IN_W-1:0];
        if (clr) begin
            for (int l = 0; l < CH; l++) m_acc[l] = 0;
            m_cnt = 0;
        end else if (v) begin
            if (m_cnt == 0) m_len = (win_len == 0) ? WIN_MAX : int'(win_len);
            for (int l = 0; l < CH; l++) m_acc[l] += smp[l];
            m_cnt++;
            if (m_cnt == m_len) begin
                for (int l = 0; l < CH; l++) begin
                    exp_v[l*OUT_W +: OUT_W] = m_acc[l][OUT_W-1:0];
                    m_acc[l] = 0;
                end
                exp_q.push_back(exp_v);
                m_cnt = 0;
                done  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        bit done;
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || win_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b dout=%h win_cnt=%0d expected 0/0/0", out_valid, dout, win_cnt);
        end
`ifdef ACCU_OVR_EN
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovr: ovr=%b expected 0", ovr);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        set_all(0);
        step(1'b0, 1'b0, done);
    endtask

    task automatic test_basic();
        bit done;
        win_len   = CW'(4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            if (i == 3) begin
                checks++;
                if (win_cnt !== CW'(3) || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_partial: win_cnt=%0d out_valid=%b expected 3/0", win_cnt, out_valid);
                end
            end
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v || win_cnt !== '0) begin
                    errors++;
                    $display("FAIL basic_result: out_valid=%b dout=%h win_cnt=%0d expected 1/%h/0", out_valid, dout, win_cnt, exp_v);
                end
                for (int l = 0; l < CH; l++) begin
                    checks++;
                    if (dout[l*OUT_W +: OUT_W] !== OUT_W'(10)) begin
                        errors++;
                        $display("FAIL basic_lane%0d: got %0d expected 10", l, dout[l*OUT_W +: OUT_W]);
                    end
                end
            end
        end
        step(1'b0, 1'b0, done);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_negative();
        bit done;
        longint neg[3];
        logic signed [OUT_W-1:0] m10;
        neg = '{-5, -7, 2};
        m10 = -10;
        win_len = CW'(3);
        for (int i = 0; i < 3; i++) begin
            set_all(0);
            smp[0] = neg[i];
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== m10) begin
                    errors++;
                    $display("FAIL negative_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end
        end
        step(1'b0, 1'b0, done);
    endtask

    task automatic test_back_to_back();
        bit done;
        int k;
        longint b2b[3];
        b2b = '{3, 7, 11};
        k = 0;
        win_len   = CW'(2);
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            checks++;
            if (done) begin
                exp_v = exp_q.pop_front();
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== b2b[k][OUT_W-1:0]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: out_valid=%b dout=%h expected 1/%h", k, out_valid, dout, exp_v);
                end
                k++;
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle: out_valid=%b expected 0", out_valid);
            end
        end
        step(1'b0, 1'b0, done);
    endtask

    task automatic test_backpressure();
        bit done;
        win_len   = CW'(2);
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v) begin
                    errors++;
                    $display("FAIL bp_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end
        end
        step(1'b0, 1'b0, done);
        checks++;
        if (out_valid !== 1'b1 || dout[OUT_W-1:0] !== OUT_W'(7)) begin
            errors++;
            $display("FAIL bp_hold: out_valid=%b lane0=%0d expected 1/7", out_valid, dout[OUT_W-1:0]);
        end
`ifdef ACCU_OVR_EN
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL bp_ovr: ovr=%b expected 1", ovr);
        end
`endif
        out_ready = 1'b1;
        step(1'b0, 1'b0, done);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_clear();
        bit done;
        win_len   = CW'(5);
        out_ready = 1'b1;
        set_all(9);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, done);
        set_all(100);
        step(1'b1, 1'b1, done);
        checks++;
        if (win_cnt !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: win_cnt=%0d out_valid=%b expected 0/0", win_cnt, out_valid);
        end
`ifdef ACCU_OVR_EN
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL clear_ovr: ovr=%b expected 0", ovr);
        end
`endif
        set_all(2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== OUT_W'(10)) begin
                    errors++;
                    $display("FAIL clear_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end
        end
        step(1'b0, 1'b0, done);
    endtask

    task automatic test_len_edges();
        bit done;
        out_ready = 1'b1;
        win_len   = CW'(1);
        for (int i = 5; i <= 7; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            exp_v = done ? exp_q.pop_front() : '0;
            checks++;
            if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== OUT_W'(i)) begin
                errors++;
                $display("FAIL len1_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
            end
        end
        step(1'b0, 1'b0, done);
        // Length latched on first sample; changing win_len mid-window must not matter.
        win_len = CW'(3);
        set_all(1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, done);
            win_len = CW'(1);
            checks++;
            if (done) begin
                exp_v = exp_q.pop_front();
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== OUT_W'(3)) begin
                    errors++;
                    $display("FAIL latch_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end else if (out_valid !== 1'b0 || win_cnt !== CW'(i)) begin
                errors++;
                $display("FAIL latch_partial: out_valid=%b win_cnt=%0d expected 0/%0d", out_valid, win_cnt, i);
            end
        end
        step(1'b0, 1'b0, done);
        win_len = '0;
        for (int i = 1; i <= WIN_MAX; i++) begin
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== OUT_W'(WIN_MAX)) begin
                    errors++;
                    $display("FAIL lenmax_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end else if (i == WIN_MAX - 1) begin
                checks++;
                if (out_valid !== 1'b0 || win_cnt !== CW'(WIN_MAX - 1)) begin
                    errors++;
                    $display("FAIL lenmax_partial: out_valid=%b win_cnt=%0d expected 0/%0d", out_valid, win_cnt, WIN_MAX - 1);
                end
            end
        end
        step(1'b0, 1'b0, done);
    endtask

    task automatic test_reset_mid();
        bit done;
        win_len   = CW'(4);
        out_ready = 1'b1;
        set_all(7);
        step(1'b1, 1'b0, done);
        step(1'b1, 1'b0, done);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || win_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid_window: out_valid=%b dout=%h win_cnt=%0d expected 0/0/0", out_valid, dout, win_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        win_len   = CW'(2);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v) begin
                    errors++;
                    $display("FAIL rst_pre_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dout !== '0 || win_cnt !== '0) begin
            errors++;
            $display("FAIL rst_held_result: out_valid=%b dout=%h win_cnt=%0d expected 0/0/0", out_valid, dout, win_cnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 3; i <= 4; i++) begin
            set_all(i);
            step(1'b1, 1'b0, done);
            if (done) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (out_valid !== 1'b1 || dout !== exp_v || dout[OUT_W-1:0] !== OUT_W'(7)) begin
                    errors++;
                    $display("FAIL rst_post_result: out_valid=%b dout=%h expected 1/%h", out_valid, dout, exp_v);
                end
            end
        end
        step(1'b0, 1'b0, done);
    endtask

    initial begin
        set_all(0);
        model_reset();
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_len_edges();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
